// File: rtl/distribute.sv
// distribute: fans an ordered, address-tagged word stream out to N
// single-entry output channels. Words must arrive in channel order
// 0, 1, ..., N-1, 0, ...; anything else is swallowed and flagged on err.
module distribute #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 2,
    localparam int unsigned A = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_stb,
    input  logic [A+W-1:0]   s_dat,
    output logic             s_rdy,
    output logic [N-1:0]     m_stb,
    output logic [N*W-1:0]   m_dat,
    input  logic [N-1:0]     m_rdy,
    output logic             err
);

    logic [A-1:0]          adr;
    logic [W-1:0]          dat;
    logic                  in_seq;
    logic                  accept;
    logic                  drop;

    logic [N-1:0]          full_q, full_d;
    logic [N-1:0][W-1:0]   slot_q;
    logic [A-1:0]          exp_q, exp_d;
    logic                  err_q, err_d;

    assign adr    = s_dat[A+W-1:W];
    assign dat    = s_dat[W-1:0];
    assign in_seq = (adr == exp_q);

    // Ready depends only on the input word and registered slot state, never on m_rdy,
    // so a slot draining this cycle cannot be refilled until the next one.
    assign s_rdy  = in_seq ? ~full_q[exp_q] : 1'b1;
    assign accept = s_stb & s_rdy & in_seq;
    assign drop   = s_stb & ~in_seq;

    // Next-state: drains clear slots, an accepted word fills the expected slot.
    always_comb begin
        full_d = full_q & ~m_rdy;
        for (int i = 0; i < N; i++) begin
            if (accept && (exp_q == A'(i))) begin
                full_d[i] = 1'b1;
            end
        end
        exp_d = exp_q;
        if (accept) begin
            exp_d = (exp_q == A'(N - 1)) ? '0 : exp_q + A'(1);
        end
        err_d = err_q | drop;
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            exp_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            exp_q  <= exp_d;
            err_q  <= err_d;
        end
    end

    // Slot data is qualified by full_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_q[exp_q] <= dat;
        end
    end

    assign m_stb = full_q;
    assign m_dat = slot_q;
    assign err   = err_q;

endmodule

// File: tb/tb_distribute.sv
// tb_distribute: directed vectors for distribute at N=2 and N=3, with a
// scoreboard queue per instance that a negedge monitor drains on each output handshake.
module tb_distribute;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N=2 instance
    logic        stb2;
    logic [8:0]  dat2;
    logic        rdy2;
    logic [1:0]  mstb2;
    logic [15:0] mdat2;
    logic [1:0]  mrdy2;
    logic        err2;

    // N=3 instance
    logic        stb3;
    logic [9:0]  dat3;
    logic        rdy3;
    logic [2:0]  mstb3;
    logic [23:0] mdat3;
    logic [2:0]  mrdy3;
    logic        err3;

    distribute #(.W(8), .N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_stb(stb2), .s_dat(dat2), .s_rdy(rdy2),
        .m_stb(mstb2), .m_dat(mdat2), .m_rdy(mrdy2), .err(err2)
    );

    distribute #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_stb(stb3), .s_dat(dat3), .s_rdy(rdy3),
        .m_stb(mstb3), .m_dat(mdat3), .m_rdy(mrdy3), .err(err3)
    );

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } ent_t;

    ent_t q2[$];
    ent_t q3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Match an output handshake against the oldest expected word for that channel.
    task automatic pop(input int which, input int c, input logic [7:0] got);
        int idx;
        idx = -1;
        total++;
        if (which == 2) begin
            for (int k = 0; k < q2.size(); k++)
                if (idx < 0 && int'(q2[k].ch) == c) idx = k;
        end else begin
            for (int k = 0; k < q3.size(); k++)
                if (idx < 0 && int'(q3[k].ch) == c) idx = k;
        end
        if (idx < 0) begin
            bad++;
            $display("FAIL sb_unexpected dut=%0d ch=%0d actual=%h required=none", which, c, got);
        end else if (which == 2) begin
            if (got !== q2[idx].d) begin
                bad++;
                $display("FAIL sb_data dut=2 ch=%0d actual=%h required=%h", c, got, q2[idx].d);
            end
            q2.delete(idx);
        end else begin
            if (got !== q3[idx].d) begin
                bad++;
                $display("FAIL sb_data dut=3 ch=%0d actual=%h required=%h", c, got, q3[idx].d);
            end
            q3.delete(idx);
        end
    endtask

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 2; c++)
                if (mstb2[c] && mrdy2[c]) pop(2, c, mdat2[c*8 +: 8]);
            for (int c = 0; c < 3; c++)
                if (mstb3[c] && mrdy3[c]) pop(3, c, mdat3[c*8 +: 8]);
        end
    end

    task automatic send2(input logic a, input logic [7:0] d, input bit deliver);
        int n;
        n = 0;
        stb2 = 1'b1;
        dat2 = {a, d};
        look();
        while (!rdy2 && n < 50) begin
            look();
            n++;
        end
        chk("send2_rdy", 32'(rdy2), 32'd1);
        if (deliver) q2.push_back({1'b0, a, d});
        step();
        stb2 = 1'b0;
    endtask

    task automatic send3(input logic [1:0] a, input logic [7:0] d, input bit deliver);
        int n;
        n = 0;
        stb3 = 1'b1;
        dat3 = {a, d};
        look();
        while (!rdy3 && n < 50) begin
            look();
            n++;
        end
        chk("send3_rdy", 32'(rdy3), 32'd1);
        if (deliver) q3.push_back({a, d});
        step();
        stb3 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stb2 = 1'b0;
        stb3 = 1'b0;
        q2.delete();
        q3.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stb2 = 1'b0; dat2 = '0; mrdy2 = '0;
        stb3 = 1'b0; dat3 = '0; mrdy3 = '0;

        // Reset state
        #1;
        chk("rst_mstb", 32'(mstb2), 32'd0);
        chk("rst_err", 32'(err2), 32'd0);
        chk("rst_rdy_adr0", 32'(rdy2), 32'd1);
        do_reset();

        // Ordered sweep, back-to-back, all ready
        mrdy2 = 2'b11;
        send2(1'b0, 8'h11, 1'b1);
        send2(1'b1, 8'h22, 1'b1);
        send2(1'b0, 8'h33, 1'b1);
        look();
        chk("sweep_stb", 32'(mstb2), 32'h1);
        chk("sweep_dat", 32'(mdat2[7:0]), 32'h33);
        chk("sweep_err", 32'(err2), 32'd0);
        step();
        look();
        chk("sweep_pulse_end", 32'(mstb2), 32'h0);
        step();

        // Backpressure on channel 0
        do_reset();
        mrdy2 = 2'b10;
        send2(1'b0, 8'hA5, 1'b1);
        send2(1'b1, 8'h5A, 1'b1);
        stb2 = 1'b1;
        dat2 = {1'b0, 8'h01};
        look();
        chk("bp_rdy_full", 32'(rdy2), 32'd0);
        chk("bp_stb0", 32'(mstb2[0]), 32'd1);
        chk("bp_dat0", 32'(mdat2[7:0]), 32'hA5);
        step();
        look();
        chk("bp_rdy_hold", 32'(rdy2), 32'd0);
        chk("bp_dat_hold", 32'(mdat2[7:0]), 32'hA5);
        step();
        mrdy2 = 2'b11;
        look();
        chk("bp_no_comb_path", 32'(rdy2), 32'd0);
        q2.push_back({2'd0, 8'h01});
        step();
        mrdy2 = 2'b10;
        look();
        chk("bp_rdy_after_drain", 32'(rdy2), 32'd1);
        chk("bp_not_same_cycle", 32'(mstb2[0]), 32'd0);
        step();
        stb2 = 1'b0;
        look();
        chk("bp_late_stb", 32'(mstb2), 32'h1);
        chk("bp_late_dat", 32'(mdat2[7:0]), 32'h01);
        step();
        mrdy2 = 2'b11;
        step();

        // Sequence error
        do_reset();
        mrdy2 = 2'b11;
        send2(1'b1, 8'h77, 1'b0);
        look();
        chk("seq_drop_stb", 32'(mstb2), 32'h0);
        chk("seq_err_set", 32'(err2), 32'd1);
        step();
        send2(1'b0, 8'h10, 1'b1);
        look();
        chk("seq_next_stb", 32'(mstb2), 32'h1);
        chk("seq_next_dat", 32'(mdat2[7:0]), 32'h10);
        chk("seq_err_sticky", 32'(err2), 32'd1);
        step();

        // Async reset mid-stream with both slots full
        do_reset();
        mrdy2 = 2'b00;
        send2(1'b1, 8'hEE, 1'b0);
        send2(1'b0, 8'hAA, 1'b1);
        send2(1'b1, 8'hBB, 1'b1);
        look();
        chk("arst_pre_full", 32'(mstb2), 32'h3);
        chk("arst_pre_err", 32'(err2), 32'd1);
        #2;
        rst_n = 1'b0;
        q2.delete();
        #1;
        chk("arst_stb_now", 32'(mstb2), 32'h0);
        chk("arst_err_now", 32'(err2), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        mrdy2 = 2'b11;
        send2(1'b0, 8'hCC, 1'b1);
        look();
        chk("arst_first_adr0", 32'(mstb2), 32'h1);
        chk("arst_first_dat", 32'(mdat2[7:0]), 32'hCC);
        chk("arst_err_clear", 32'(err2), 32'd0);
        step();

        // Concurrent drain of slot 0 and fill of slot 1
        do_reset();
        mrdy2 = 2'b00;
        send2(1'b0, 8'hE1, 1'b1);
        mrdy2 = 2'b01;
        stb2 = 1'b1;
        dat2 = {1'b1, 8'h42};
        look();
        chk("cc_rdy", 32'(rdy2), 32'd1);
        q2.push_back({2'd1, 8'h42});
        step();
        stb2 = 1'b0;
        mrdy2 = 2'b00;
        look();
        chk("cc_stb", 32'(mstb2), 32'h2);
        chk("cc_dat1", 32'(mdat2[15:8]), 32'h42);
        step();
        mrdy2 = 2'b11;
        step();

        // Wrap with N=3, then out-of-range address
        do_reset();
        mrdy3 = 3'b111;
        for (int k = 0; k < 6; k++) send3(2'(k % 3), 8'(8'h30 + k), 1'b1);
        look();
        chk("wrap_err_clear", 32'(err3), 32'd0);
        step();
        send3(2'd3, 8'h99, 1'b0);
        look();
        chk("wrap_bad_adr_err", 32'(err3), 32'd1);
        chk("wrap_bad_adr_stb", 32'(mstb3), 32'h0);
        step();
        send3(2'd0, 8'h3F, 1'b1);

        // Drain and confirm every expected word came out
        mrdy2 = 2'b11;
        mrdy3 = 3'b111;
        repeat (4) step();
        chk("sb_empty_n2", 32'(q2.size()), 32'd0);
        chk("sb_empty_n3", 32'(q3.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/distribute.md
# distribute

Routing stage that takes a single ordered stream of address-tagged words, `{adr, dat}`, and delivers each word to one of N independent output channels, each with its own valid/ready handshake. Every channel holds a one-entry slot, so channels drain at their own pace. Input order is enforced (0, 1, …, N-1, 0, …); out-of-sequence words are discarded and flagged. This block sits downstream of the serializing reorder stage and fans its output back out to per-unit consumers.

## Interface
- `W`, 8: data width per word
- `N`, 2: number of output channels; must be ≥ 2; `A = $clog2(N)`
- `clk`  in  1  clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low; deasserted synchronously with `clk`
- `s_stb`  in  1  input word valid
- `s_dat`  in  A+W  input word: `{adr[A-1:0], dat[W-1:0]}`
- `s_rdy`  out  1  input ready
- `m_stb`  out  N  per-channel valid; bit i belongs to channel i
- `m_dat`  out  N*W  per-channel data; channel i occupies bits `[i*W +: W]`
- `m_rdy`  in  N  per-channel ready
- `err`  out  1  sticky sequence error

## Operation
- State:
  - `full[N-1:0]`: slot occupied
  - `slot[i][W-1:0]`: slot data
  - `exp[A-1:0]`: expected address
  - `err`: sticky error flag
- Decode: `adr = s_dat[A+W-1:W]` and `dat = s_dat[W-1:0]`.
- In-sequence word (`adr == exp`):
  - `s_rdy = ~full[adr]`.
  - On handshake (`s_stb & s_rdy`): `slot[adr] <= dat`, `full[adr] <= 1`.
  - `exp` advances by 1, wrapping from N-1 to 0. Wrap applies for any N, including non-powers of two.
- Out-of-sequence word (`adr != exp`, including `adr >= N`):
  - `s_rdy = 1`.
  - On handshake the word is dropped, `err <= 1`, and `exp` is unchanged.
- Output channel i:
  - `m_stb[i] = full[i]` and `m_dat[i] = slot[i]`.
  - On `m_stb[i] & m_rdy[i]`: `full[i] <= 0`.
- `s_rdy` is a function of registered state and `s_dat` only. There is no combinational path from `m_rdy` to `s_rdy`.
- Same slot drained and targeted in one cycle:
  - The drain takes effect.
  - The input is not accepted, because `full` was 1 when `s_rdy` was evaluated.
  - The write happens no earlier than the next cycle.
- Drain of slot j and write of slot k ≠ j in one cycle: both take effect.
- `err` stays set until reset.
- Reset (async, any time, including mid-stream): `full = 0`, `exp = 0`, `err = 0`, `m_stb = 0`, `s_rdy = 1` for `adr = 0`. Slot data is don't-care and is not reset.

## Timing
- Input-to-output latency: 1 cycle. A word accepted on edge k drives `m_stb[adr] = 1` after edge k.
- Aggregate input throughput: one word per cycle, provided the targeted slots are empty.
- Per-channel throughput: one word per 2 cycles at most, because a slot cannot be refilled in the cycle it drains.
- `m_stb[i]` and `m_dat[i]` stay stable while `m_rdy[i] = 0`.
- A stalled channel blocks the whole input, since order is strict.
- All outputs are registered, except `s_rdy`, which is combinational from `s_dat` and state.

## Test plan
- Ordered sweep, N=2, W=8, all `m_rdy = 1`:
  - Stimulus: send `{0,0x11}`, `{1,0x22}`, `{0,0x33}` on consecutive cycles.
  - Required: `m_dat[7:0] = 0x11`, then `m_dat[15:8] = 0x22`, then `m_dat[7:0] = 0x33`; each `m_stb` pulse is 1 cycle wide, 1 cycle after acceptance; `err = 0`.
- Backpressure, `m_rdy[0] = 0`:
  - Stimulus: send `{0,0xA5}`, `{1,0x5A}`, then present `{0,0x01}`.
  - Required: `s_rdy = 0` while `full[0]`; `m_dat[7:0]` holds `0xA5`.
  - Then raise `m_rdy[0]` for 1 cycle. Required: `0x01` is accepted on the following cycle, not the same cycle.
- Sequence error:
  - Stimulus: with `exp = 0`, send `{1,0x77}`.
  - Required: accepted and dropped; `m_stb` stays 0; `err = 1`; a subsequent `{0,0x10}` is delivered on channel 0; `err` stays 1.
- Wrap with N=3:
  - Stimulus: send addresses 0,1,2,0,1,2.
  - Required: all delivered in order; `exp` wraps 2→0.
  - Stimulus: send `adr = 3`. Required: `err = 1`.
- Async reset mid-stream:
  - Stimulus: assert `rst_n = 0` between edges while `full = 2'b11`.
  - Required: `m_stb = 0` immediately, without waiting for a clock edge; `err = 0`; after release, the first word accepted is `adr = 0`.
- Concurrent drain and fill:
  - Setup: N=2, `full[0] = 1`.
  - Stimulus: in one cycle, `m_rdy[0] = 1` and send `{1,0x42}`.
  - Required: both take effect; next cycle `m_stb = 2'b10`, `m_dat[15:8] = 0x42`.
